// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with per-digit blink, decimal points and tear-free LOAD/PENDING updates.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits when staged data is captured into the shadow.
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                LOAD,
  input  logic [5*DIGITS-1:0] SEG7DATA,
  input  logic [DIGITS-1:0]   SEG7BLINK,
  input  logic [DIGITS-1:0]   DP_IN,
  output logic                PENDING,
  output logic                FRAME_TICK,
  output logic [DIGITS-1:0]   AN,
  output logic [6:0]          SEG,
  output logic                DP
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [4:0] CODE_BLANK = 5'h11;

  logic [PW-1:0] presc_reg, presc_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          blink_phase_reg, blink_phase_next;
  logic          tick_reg;
  logic          terminal, frame_bnd;

  logic [4:0]        load_code [DIGITS];
  logic [4:0]        src_code [DIGITS];
  logic [4:0]        cap_code [DIGITS];
  logic [DIGITS-1:0] src_dp, src_blink;

  logic [4:0]        staging_code_reg [DIGITS];
  logic [DIGITS-1:0] staging_blink_reg, staging_dp_reg;
  logic [4:0]        shadow_code_reg [DIGITS];
  logic [DIGITS-1:0] shadow_blink_reg, shadow_dp_reg;
  logic              pending_reg;

  logic [DIGITS-1:0] an_reg;
  logic [6:0]        seg_reg;
  logic              dp_reg;
  logic              blank_now;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    s = 7'h7F;
    if (!code[4]) begin
      case (code[3:0])
        4'h0: s = 7'b1000000;
        4'h1: s = 7'b1111001;
        4'h2: s = 7'b0100100;
        4'h3: s = 7'b0110000;
        4'h4: s = 7'b0011001;
        4'h5: s = 7'b0010010;
        4'h6: s = 7'b0000010;
        4'h7: s = 7'b1111000;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0010000;
        4'hA: s = 7'b0001000;
        4'hB: s = 7'b0000011;
        4'hC: s = 7'b1000110;
        4'hD: s = 7'b0100001;
        4'hE: s = 7'b0000110;
        default: s = 7'b0001110;
      endcase
    end else if (code == 5'h10) begin
      s = 7'b0111111;
    end
    return s;
  endfunction

  assign terminal  = (presc_reg == PW'(SCAN_DIV - 1));
  assign frame_bnd = terminal && (idx_reg == IW'(DIGITS - 1));

  always_comb begin
    presc_next       = presc_reg + 1'b1;
    idx_next         = idx_reg;
    frame_cnt_next   = frame_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (terminal) begin
      presc_next = '0;
      idx_next   = idx_reg + 1'b1;
      if (frame_bnd) begin
        idx_next = '0;
        if (frame_cnt_reg == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt_next   = '0;
          blink_phase_next = ~blink_phase_reg;
        end else begin
          frame_cnt_next = frame_cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_reg       <= '0;
      idx_reg         <= '0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      tick_reg        <= 1'b0;
    end else begin
      presc_reg       <= presc_next;
      idx_reg         <= idx_next;
      frame_cnt_reg   <= frame_cnt_next;
      blink_phase_reg <= blink_phase_next;
      tick_reg        <= frame_bnd;
    end
  end

  // A LOAD on the boundary cycle bypasses staging so it lands in this frame swap.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_src
      assign load_code[gi] = SEG7DATA[5*gi +: 5];
      assign src_code[gi]  = LOAD ? load_code[gi] : staging_code_reg[gi];
    end
  endgenerate
  assign src_dp    = LOAD ? DP_IN : staging_dp_reg;
  assign src_blink = LOAD ? SEG7BLINK : staging_blink_reg;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lzb_run;
  always_comb begin
    lzb_run = 1'b1;
    for (int i = 0; i < DIGITS; i++) cap_code[i] = src_code[i];
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lzb_run && (src_code[i] == 5'h00) && !src_dp[i]) cap_code[i] = CODE_BLANK;
      else lzb_run = 1'b0;
    end
  end
`else
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_cap
      assign cap_code[gi] = src_code[gi];
    end
  endgenerate
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DIGITS; i++) begin
        staging_code_reg[i] <= CODE_BLANK;
        shadow_code_reg[i]  <= CODE_BLANK;
      end
      staging_blink_reg <= '0;
      staging_dp_reg    <= '0;
      shadow_blink_reg  <= '0;
      shadow_dp_reg     <= '0;
      pending_reg       <= 1'b0;
    end else begin
      if (LOAD) begin
        for (int i = 0; i < DIGITS; i++) staging_code_reg[i] <= load_code[i];
        staging_blink_reg <= SEG7BLINK;
        staging_dp_reg    <= DP_IN;
      end
      if (frame_bnd) begin
        for (int i = 0; i < DIGITS; i++) shadow_code_reg[i] <= cap_code[i];
        shadow_blink_reg <= src_blink;
        shadow_dp_reg    <= src_dp;
        pending_reg      <= 1'b0;
      end else if (LOAD) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign blank_now = blink_phase_reg && shadow_blink_reg[idx_reg];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      an_reg  <= '1;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= ~(DIGITS'(1) << idx_reg);
      seg_reg <= blank_now ? 7'h7F : decode(shadow_code_reg[idx_reg]);
      dp_reg  <= blank_now ? 1'b1 : ~shadow_dp_reg[idx_reg];
    end
  end

  assign AN         = an_reg;
  assign SEG        = seg_reg;
  assign DP         = dp_reg;
  assign PENDING    = pending_reg;
  assign FRAME_TICK = tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected digit slots and frame ticks are queued by the
// stimulus and consumed by a monitor whenever AN moves to a new digit or FRAME_TICK pulses.
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        LOAD = 1'b0;
  logic [19:0] SEG7DATA = '0;
  logic [3:0]  SEG7BLINK = '0;
  logic [3:0]  DP_IN = '0;
  logic        PENDING, FRAME_TICK, DP;
  logic [3:0]  AN;
  logic [6:0]  SEG;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .SEG7DATA(SEG7DATA), .SEG7BLINK(SEG7BLINK),
    .DP_IN(DP_IN), .PENDING(PENDING), .FRAME_TICK(FRAME_TICK), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t slot_q[$];
  int    tick_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  logic [3:0] prev_an = 4'hF;

  always @(posedge CLK) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    slot_t e;
    int t;
    if (!RST_N) begin
      prev_an = 4'hF;
    end else begin
      if (AN != prev_an && slot_q.size() > 0 && slot_q[0].cyc <= cyc) begin
        e = slot_q.pop_front();
        checks++;
        if (e.cyc != cyc || {AN, SEG, DP} != {e.an, e.seg, e.dp}) begin
          failures++;
          $display("FAIL slot at cyc=%0d (required cyc=%0d): an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                   cyc, e.cyc, AN, SEG, DP, e.an, e.seg, e.dp);
        end else begin
          $display("slot cyc=%0d an=%b seg=%h dp=%b ok", cyc, AN, SEG, DP);
        end
      end
      prev_an = AN;
      if (FRAME_TICK) begin
        checks++;
        if (tick_q.size() == 0) begin
          failures++;
          $display("FAIL frame_tick unexpected at cyc=%0d, required none", cyc);
        end else begin
          t = tick_q.pop_front();
          if (t != cyc) begin
            failures++;
            $display("FAIL frame_tick at cyc=%0d, required cyc=%0d", cyc, t);
          end else begin
            $display("frame_tick cyc=%0d ok", cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic load(input int n, input logic [19:0] d, input logic [3:0] b, input logic [3:0] p);
    goto(n - 1);
    SEG7DATA  = d;
    SEG7BLINK = b;
    DP_IN     = p;
    LOAD      = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  // segs = {digit3,digit2,digit1,digit0}; dpn is the active-low DP pin value per digit
  task automatic push_frame(input int f, input logic [27:0] segs, input logic [3:0] dpn);
    slot_t e;
    for (int d = 0; d < 4; d++) begin
      e.cyc = (4 * f + d) * 4 + 1;
      e.an  = ~(4'b0001 << d);
      e.seg = segs[7*d +: 7];
      e.dp  = dpn[d];
      slot_q.push_back(e);
    end
  endtask

  localparam logic [27:0] BLANK4 = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_an", 32'(AN), 32'hF);
    chk("reset_seg", 32'(SEG), 32'h7F);
    chk("reset_dp", 32'(DP), 32'h1);
    chk("reset_pending", 32'(PENDING), 32'h0);
    chk("reset_tick", 32'(FRAME_TICK), 32'h0);

    push_frame(0, BLANK4, 4'hF);
    push_frame(1, BLANK4, 4'hF);
    for (int k = 1; k <= 11; k++) tick_q.push_back(16 * k);
    RST_N = 1'b1;

    goto(10);
    chk("idle_pending", 32'(PENDING), 32'h0);

    // single LOAD mid-frame 1, shown from frame 2
    load(20, {5'h11, 5'h11, 5'h0A, 5'h03}, 4'b0000, 4'b0000);
    chk("load1_pending_set", 32'(PENDING), 32'h1);
    push_frame(2, {7'h7F, 7'h7F, 7'h08, 7'h30}, 4'hF);
    goto(31);
    chk("load1_pending_hold", 32'(PENDING), 32'h1);
    goto(32);
    chk("load1_pending_clear", 32'(PENDING), 32'h0);

    // two LOADs in frame 2: last write wins in frame 3
    load(36, {5'h04, 5'h03, 5'h02, 5'h01}, 4'b0000, 4'b0000);
    chk("load2_pending_set", 32'(PENDING), 32'h1);
    load(40, {5'h08, 5'h07, 5'h06, 5'h05}, 4'b0000, 4'b0000);
    push_frame(3, {7'h00, 7'h78, 7'h02, 7'h12}, 4'hF);
    goto(47);
    chk("load3_pending_hold", 32'(PENDING), 32'h1);
    goto(48);
    chk("load3_pending_clear", 32'(PENDING), 32'h0);

    // blink + DP on digit 0: lit frames 4,5,8; blanked frames 6,7
    load(52, {5'h10, 5'h0F, 5'h0C, 5'h08}, 4'b0001, 4'b0001);
    for (int f = 4; f <= 8; f++) begin
      if (f == 6 || f == 7) push_frame(f, {7'h3F, 7'h0E, 7'h46, 7'h7F}, 4'b1111);
      else                  push_frame(f, {7'h3F, 7'h0E, 7'h46, 7'h00}, 4'b1110);
    end

    // LOAD on the boundary edge 144: visible from frame 9, PENDING never rises
    push_frame(9,  {7'h40, 7'h79, 7'h03, 7'h21}, 4'b1101);
    push_frame(10, {7'h40, 7'h79, 7'h03, 7'h21}, 4'b1101);
    load(144, {5'h00, 5'h01, 5'h0B, 5'h0D}, 4'b0000, 4'b0010);
    chk("bnd_load_pending", 32'(PENDING), 32'h0);
    SEG7DATA  = {5'h08, 5'h08, 5'h08, 5'h08};
    SEG7BLINK = 4'b1111;
    DP_IN     = 4'b1111;
    goto(145);
    chk("bnd_load_pending_next", 32'(PENDING), 32'h0);

    // LOAD then asynchronous reset mid-frame
    load(180, {5'h01, 5'h01, 5'h01, 5'h01}, 4'b0000, 4'b0000);
    chk("pre_reset_pending", 32'(PENDING), 32'h1);
    goto(181);
    chk("slot_q_drained_before_reset", 32'(slot_q.size()), 32'h0);
    chk("tick_q_drained_before_reset", 32'(tick_q.size()), 32'h0);
    goto(182);
    #2 RST_N = 1'b0;
    #1;
    chk("async_reset_an", 32'(AN), 32'hF);
    chk("async_reset_seg", 32'(SEG), 32'h7F);
    chk("async_reset_dp", 32'(DP), 32'h1);
    chk("async_reset_pending", 32'(PENDING), 32'h0);
    repeat (2) @(negedge CLK);
    push_frame(0, BLANK4, 4'hF);
    push_frame(1, BLANK4, 4'hF);
    tick_q.push_back(16);
    tick_q.push_back(32);
    RST_N = 1'b1;

    goto(5);
    chk("post_reset_pending", 32'(PENDING), 32'h0);
    goto(40);
    chk("slot_q_drained_end", 32'(slot_q.size()), 32'h0);
    chk("tick_q_drained_end", 32'(tick_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver for N digits, with per-digit blink, decimal points and tear-free frame updates.
- Sits between datapath display formatting (dividend/divisor/quotient/remainder select) and the board's common-anode digit/segment pins.
- Replaces free-running external scan logic: owns the refresh prescaler, blink timebase, hex decode and a LOAD/PENDING handshake.

Parameters:
- DIGITS, 4, number of digits scanned; legal 1..8.
- SCAN_DIV, 50000, CLK cycles each digit stays enabled; legal >= 2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; legal >= 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- LOAD  in  1  one-cycle strobe; captures SEG7DATA/SEG7BLINK/DP_IN into staging.
- SEG7DATA  in  5*DIGITS  per-digit code; digit k = bits [5k+4:5k].
- SEG7BLINK  in  DIGITS  bit k=1 blinks digit k.
- DP_IN  in  DIGITS  bit k=1 lights the decimal point of digit k.
- PENDING  out  1  high from a LOAD until the staged data reaches the display.
- FRAME_TICK  out  1  one-cycle pulse at each frame boundary.
- AN  out  DIGITS  digit enables, active-low, one-hot-low.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low; SEG[0]=a.
- DP  out  1  decimal point, active-low.

Behaviour:
- Reset, asynchronous on RST_N low:
  - prescaler=0, digit index=0, frame counter=0, blink phase=0.
  - staging and shadow codes = 5'h11 (blank); blink/DP masks = 0.
  - PENDING=0, FRAME_TICK=0, AN=all 1, SEG=7'h7F, DP=1.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. On the terminal count, the index advances by 1.
- Frame boundary: the terminal-count cycle when index=DIGITS-1.
  - Index wraps to 0.
  - FRAME_TICK is registered high for exactly one cycle.
  - Frame counter advances. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
- Code decode, per 5-bit code:
  - bit4=0: hex 0-F on a standard 7-seg map. 0 -> 7'b1000000, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110.
  - 5'h10: dash, 7'b0111111.
  - Any other bit4=1 code: blank, 7'h7F.
- Output stage: AN, SEG and DP are registered from the current index and shadow, so state-to-pin latency is 1 cycle.
  - AN[index]=0, all other bits 1.
  - The first digit-0 enable appears on the first edge after RST_N deasserts.
- Blink: when blink phase=1 and shadow blink bit of the indexed digit is 1, SEG=7'h7F and DP=1. AN still scans normally, so timing is unaffected.
- DP output = ~shadow_dp[index], subject to the blink blanking above.
- Handshake:
  - LOAD copies the inputs into staging in the same edge and sets PENDING.
  - At the next frame boundary, staging is copied to shadow and PENDING clears.
  - A second LOAD while PENDING=1 overwrites staging; last write wins.
  - LOAD coincident with a frame boundary: the current-cycle inputs go straight to shadow, and PENDING stays 0.
  - Shadow never changes mid-frame.
- Inputs are not sampled without LOAD; input changes without LOAD have no visible effect.
- DIGITS=1: every terminal count is a frame boundary, and AN is constantly 0 after the first edge.
- Reset mid-frame: all state is lost, including staged data. The display is blank until a LOAD and the next frame boundary.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: at shadow capture, a run of code 5'h00 digits from digit DIGITS-1 downward is rewritten to blank 5'h11. The run stops at the first non-zero digit or at any digit whose DP bit is set. Digit 0 is never blanked.
- Undefined: codes are displayed exactly as loaded; no extra logic.

Test Plan:
Bench parameters: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset release, no LOAD -> AN cycles 1110,1101,1011,0111 every 4 cycles; SEG=7F throughout; FRAME_TICK once per 16 cycles; PENDING=0.
- LOAD with SEG7DATA={5'h11,5'h11,5'h0A,5'h03} mid-frame -> PENDING=1 until the next FRAME_TICK; the next frame shows SEG=0110000 (3) on AN=1110, 0001000 (A) on 1101, and 7F on 1011 and 0111.
- LOAD digits 1,2,3,4 then LOAD 5,6,7,8 in the same frame -> the next frame shows 5,6,7,8 only; 1..4 never appear.
- SEG7BLINK=4'b0001, DP_IN=4'b0001 -> digit 0 lit with DP=0 for 2 frames, then SEG=7F and DP=1 for 2 frames, repeating. Other digits are unaffected and AN cadence is unchanged.
- LOAD asserted exactly on the frame-boundary cycle -> PENDING never rises; new data is visible from the following digit-0 slot.
- RST_N pulsed low mid-frame after a LOAD -> outputs go to reset values asynchronously; after release the display is blank and PENDING=0.
